cic_decim_ctrl: RTL

Sequencer for the third-order sigma-delta CIC decimator. Generates the filter's divided_clk from a programmable power-of-two ratio and holds the filter in reset across (re)configuration. Discards the CIC settling samples, then captures each decimated output into a small FIFO presented on a valid/ready interface. Sits between the CIC filter and the readout/serializer logic.

---
 rtl/cic_decim_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cic_decim_ctrl.sv
// Sequencer for the third-order CIC decimator: divided clock, filter reset, settle discard and output FIFO.
// Optional build macro CIC_CTRL_TAG_EN adds an 8-bit sequence tag per captured sample.
module cic_decim_ctrl #(
    parameter int MAX_LOG2_D = 8,
    parameter int NUMBITS    = 3*MAX_LOG2_D+1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [3:0]         log2_dec,
    input  logic               cfg_load,
    input  logic [NUMBITS-1:0] cic_data,
    output logic               cic_rst_n,
    output logic               divided_clk,
    output logic [NUMBITS-1:0] sample_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overflow,
    input  logic               overflow_clr,
    output logic [1:0]         state
`ifdef CIC_CTRL_TAG_EN
    ,
    output logic [7:0]         sample_seq
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, SETTLE = 2'd2, RUN = 2'd3} state_t;

    localparam int CW = MAX_LOG2_D;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    state_t             state_q, state_d;
    logic [3:0]         act_log2_q, act_log2_d, clamp_log2;
    logic               flush_cnt_q, flush_cnt_d;
    logic [1:0]         settle_cnt_q, settle_cnt_d;
    logic [CW-1:0]      cnt_q, cnt_d, d_last, half_bit;
    logic               cic_rst_n_q, cic_rst_n_d, div_clk_q, div_clk_d;
    logic [NUMBITS-1:0] mem_q [FIFO_DEPTH];
    logic [NUMBITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]      count_q, count_d;
    logic [NUMBITS-1:0] head_q, head_d;
    logic               valid_q, valid_d, ovf_q, ovf_d;
    logic               counting, strobe, pop, clear, push_req, full, push, drop;
`ifdef CIC_CTRL_TAG_EN
    logic [7:0]         seq_q, seq_d, head_seq_q, head_seq_d;
    logic [7:0]         seq_mem_q [FIFO_DEPTH];
    logic [7:0]         seq_mem_d [FIFO_DEPTH];
`endif

    // D-1 and the MSB of the count range; divided_clk is that MSB, so high for cnt in D/2..D-1.
    always_comb begin
        clamp_log2 = log2_dec;
        if (log2_dec < 4'd2)
            clamp_log2 = 4'd2;
        else if (log2_dec > 4'(MAX_LOG2_D))
            clamp_log2 = 4'(MAX_LOG2_D);
        d_last   = {CW{1'b1}} >> (CW - int'(act_log2_q));
        half_bit = d_last ^ (d_last >> 1);
        counting = (state_q == SETTLE) || (state_q == RUN);
        strobe   = counting && (cnt_q == d_last);
        pop      = valid_q && sample_ready;
    end

    always_comb begin
        state_d      = state_q;
        act_log2_d   = act_log2_q;
        flush_cnt_d  = flush_cnt_q;
        settle_cnt_d = settle_cnt_q;
        clear        = 1'b0;
        case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (enable) begin
                    state_d     = FLUSH;
                    act_log2_d  = clamp_log2;
                    flush_cnt_d = 1'b0;
                end
            end
            FLUSH: begin
                clear        = 1'b1;
                settle_cnt_d = 2'd0;
                if (!enable)
                    state_d = IDLE;
                else if (flush_cnt_q)
                    state_d = SETTLE;
                else
                    flush_cnt_d = 1'b1;
            end
            default: begin
                // enable low takes priority over a coincident cfg_load
                if (!enable) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else if (cfg_load) begin
                    state_d     = FLUSH;
                    act_log2_d  = clamp_log2;
                    flush_cnt_d = 1'b0;
                    clear       = 1'b1;
                end else if (strobe && state_q == SETTLE) begin
                    settle_cnt_d = settle_cnt_q + 2'd1;
                    if (settle_cnt_q == 2'd2)
                        state_d = RUN;
                end
            end
        endcase

        cnt_d = '0;
        if (counting && (state_d == SETTLE || state_d == RUN))
            cnt_d = strobe ? '0 : cnt_q + CW'(1);
        div_clk_d   = |(cnt_d & half_bit);
        cic_rst_n_d = (state_d == SETTLE) || (state_d == RUN);
    end

    // Output handshake: the head word transfers on any clk where sample_valid && sample_ready;
    // sample_data is stable while valid is high and ready is low.
    always_comb begin
        push_req = (state_q == RUN) && strobe && !clear;
        full     = (count_q == NW'(FIFO_DEPTH));
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
`ifdef CIC_CTRL_TAG_EN
        seq_mem_d = seq_mem_q;
        seq_d     = seq_q;
        if (state_q == IDLE || state_q == FLUSH)
            seq_d = 8'd0;
        else if (state_q == RUN && strobe)
            seq_d = seq_q + 8'd1;
`endif
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = cic_data;
`ifdef CIC_CTRL_TAG_EN
                seq_mem_d[wr_ptr_q] = seq_q;
`endif
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + NW'(push) - NW'(pop);
        end
        valid_d = (count_d != '0);
        head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
`ifdef CIC_CTRL_TAG_EN
        head_seq_d = valid_d ? seq_mem_d[rd_ptr_d] : 8'd0;
`endif
        ovf_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            act_log2_q   <= 4'd2;
            flush_cnt_q  <= 1'b0;
            settle_cnt_q <= 2'd0;
            cnt_q        <= '0;
            cic_rst_n_q  <= 1'b0;
            div_clk_q    <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef CIC_CTRL_TAG_EN
            seq_q        <= 8'd0;
            head_seq_q   <= 8'd0;
            seq_mem_q    <= '{default: '0};
`endif
        end else begin
            state_q      <= state_d;
            act_log2_q   <= act_log2_d;
            flush_cnt_q  <= flush_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            cnt_q        <= cnt_d;
            cic_rst_n_q  <= cic_rst_n_d;
            div_clk_q    <= div_clk_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
`ifdef CIC_CTRL_TAG_EN
            seq_q        <= seq_d;
            head_seq_q   <= head_seq_d;
            seq_mem_q    <= seq_mem_d;
`endif
        end
    end

    assign state        = state_q;
    assign cic_rst_n    = cic_rst_n_q;
    assign divided_clk  = div_clk_q;
    assign sample_data  = head_q;
    assign sample_valid = valid_q;
    assign overflow     = ovf_q;
`ifdef CIC_CTRL_TAG_EN
    assign sample_seq   = head_seq_q;
`endif

endmodule
